// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder.
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BCD_MAX = 9;
   localparam int unsigned BCD_ADJ = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit of addition with +6 correction; purely combinational.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               ci,
   output logic [DIGIT_W-1:0] s,
   output logic               co
);

   logic [DIGIT_W:0] t;

   // Binary sum, then fold anything above nine back into a decimal digit.
   always_comb begin
      t  = (DIGIT_W+1)'(x) + (DIGIT_W+1)'(y) + (DIGIT_W+1)'(ci);
      s  = t[DIGIT_W-1:0];
      co = 1'b0;
      if (t > (DIGIT_W+1)'(BCD_MAX)) begin
         s  = DIGIT_W'(t + (DIGIT_W+1)'(BCD_ADJ));
         co = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, carry kept in a register.
// Defining BCD_SUB_EN adds a 'sub' port that computes A - B by nines' complement.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
`ifdef BCD_SUB_EN
   input  logic                      sub,
`endif
   input  logic [DIGIT_W*DIGITS-1:0] a,
   input  logic [DIGIT_W*DIGITS-1:0] b,
   input  logic                      c_in,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] sum,
   output logic                      c_out,
   output logic                      invalid
);

   localparam int unsigned W      = DIGIT_W * DIGITS;
   localparam int unsigned K_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(DIGITS - 1);

   state_t             state;
   logic [K_W-1:0]     k;
   logic [W-1:0]       a_r;
   logic [W-1:0]       b_r;
   logic [W-1:0]       res_r;
   logic               carry_r;
`ifdef BCD_SUB_EN
   logic               sub_r;
`endif

   logic [DIGIT_W-1:0] a_dig;
   logic [DIGIT_W-1:0] b_dig;
   logic [DIGIT_W-1:0] y_dig;
   logic [DIGIT_W-1:0] s_dig;
   logic               co_dig;
   logic               inv_c;

   // Pick digit k of each captured operand; in subtract mode B is nines'-complemented.
   always_comb begin
      a_dig = a_r[DIGIT_W*k +: DIGIT_W];
      b_dig = b_r[DIGIT_W*k +: DIGIT_W];
`ifdef BCD_SUB_EN
      y_dig = sub_r ? (DIGIT_W'(BCD_MAX) - b_dig) : b_dig;
`else
      y_dig = b_dig;
`endif
   end

   bcd_digit_adder u_digit (
      .x  (a_dig),
      .y  (y_dig),
      .ci (carry_r),
      .s  (s_dig),
      .co (co_dig)
   );

   // Flags any non-decimal digit in the captured (uncomplemented) operands.
   always_comb begin
      inv_c = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if ((a_r[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ||
             (b_r[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX))) begin
            inv_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         carry_r <= 1'b0;
`ifdef BCD_SUB_EN
         sub_r   <= 1'b0;
`endif
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         c_out   <= 1'b0;
         invalid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
`ifdef BCD_SUB_EN
                  sub_r   <= sub;
                  carry_r <= sub | c_in;
`else
                  carry_r <= c_in;
`endif
                  k       <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               res_r[DIGIT_W*k +: DIGIT_W] <= s_dig;
               carry_r                     <= co_dig;
               if (k == K_LAST) begin
                  k     <= '0;
                  state <= DONE;
               end else begin
                  k <= k + K_W'(1);
               end
            end
            DONE: begin
               done    <= 1'b1;
               sum     <= res_r;
               c_out   <= carry_r;
               invalid <= inv_c;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
